// File: rtl/disp_pkg.sv
// Shared definitions for the seven-segment display scheduler: state/source
// encoding and the leading-zero blanking mask.
package disp_pkg;

  localparam int unsigned VAL_W = 16;
  localparam int unsigned DIG_N = 4;

  typedef enum logic [1:0] {
    S_SCORE = 2'd0,
    S_LEVEL = 2'd1,
    S_MSG   = 2'd2,
    S_OVER  = 2'd3
  } state_t;

  // Source codes shown on src_sel match the state encoding one-to-one.
  localparam logic [1:0] SRC_SCORE = 2'd0;
  localparam logic [1:0] SRC_LEVEL = 2'd1;
  localparam logic [1:0] SRC_MSG   = 2'd2;
  localparam logic [1:0] SRC_OVER  = 2'd3;

  // Light nibbles 0..k where k is the highest nonzero nibble; zero keeps digit 0.
  function automatic logic [DIG_N-1:0] lz_mask(input logic [VAL_W-1:0] v);
    if (v[15:12] != 4'h0)      lz_mask = 4'b1111;
    else if (v[11:8] != 4'h0)  lz_mask = 4'b0111;
    else if (v[7:4] != 4'h0)   lz_mask = 4'b0011;
    else                       lz_mask = 4'b0001;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running prescaler: one-cycle tick every PRESC_DIV clk cycles.
module tick_prescaler #(
  parameter int unsigned PRESC_DIV = 50000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int unsigned CW = $clog2(PRESC_DIV);

  logic [CW-1:0] cnt;

  // tick is registered one count early so it is high exactly while cnt = PRESC_DIV-1.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      if (cnt == CW'(PRESC_DIV - 1)) cnt <= '0;
      else                           cnt <= cnt + CW'(1);
      tick <= (cnt == CW'(PRESC_DIV - 2));
    end
  end

endmodule

// File: rtl/display_sched.sv
// Time-shares the 4-digit display between score, level, timed messages and
// a blinking game-over mode; dwell times are counted in prescaler ticks.
module display_sched
  import disp_pkg::*;
#(
  parameter int unsigned PRESC_DIV   = 50000,
  parameter int unsigned ROT_TICKS   = 2000,
  parameter int unsigned MSG_TICKS   = 1500,
  parameter int unsigned BLINK_TICKS = 250,
  parameter int unsigned LZ_BLANK    = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] score_val,
  input  logic [15:0] level_val,
  input  logic [15:0] msg_val,
  input  logic        msg_req,
  input  logic        game_over,
  output logic [15:0] disp_val,
  output logic [3:0]  digit_en,
  output logic [1:0]  src_sel,
  output logic        msg_ack,
  output logic        msg_busy
);

  localparam logic [15:0] ROT_L   = 16'(ROT_TICKS);
  localparam logic [15:0] MSG_L   = 16'(MSG_TICKS);
  localparam logic [15:0] BLINK_L = 16'(BLINK_TICKS);

  logic        tick;
  state_t      state_q, state_d, resume_q, resume_d;
  logic [15:0] dwell_q, dwell_d, dwell_inc, lim;
  logic [15:0] msg_q, msg_d;
  logic        phase_q, phase_d;
  logic [15:0] disp_d;
  logic [3:0]  en_d;
  logic [1:0]  src_d;
  logic        ack_d, busy_d;

  tick_prescaler #(.PRESC_DIV(PRESC_DIV)) u_presc (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_SCORE;
      resume_q <= S_SCORE;
      dwell_q  <= '0;
      msg_q    <= '0;
      phase_q  <= 1'b1;
      disp_val <= '0;
      digit_en <= 4'b0001;
      src_sel  <= SRC_SCORE;
      msg_ack  <= 1'b0;
      msg_busy <= 1'b0;
    end else begin
      state_q  <= state_d;
      resume_q <= resume_d;
      dwell_q  <= dwell_d;
      msg_q    <= msg_d;
      phase_q  <= phase_d;
      disp_val <= disp_d;
      digit_en <= en_d;
      src_sel  <= src_d;
      msg_ack  <= ack_d;
      msg_busy <= busy_d;
    end
  end

  // Next state in priority order; outputs are decoded from the next state
  // so they land in the same cycle as the state register.
  always_comb begin
    state_d   = state_q;
    resume_d  = resume_q;
    dwell_d   = dwell_q;
    msg_d     = msg_q;
    phase_d   = phase_q;
    ack_d     = 1'b0;
    dwell_inc = dwell_q + 16'd1;

    case (state_q)
      S_MSG:   lim = MSG_L;
      S_OVER:  lim = BLINK_L;
      default: lim = ROT_L;
    endcase

    if (game_over && state_q != S_OVER) begin
      state_d = S_OVER;
      dwell_d = '0;
      phase_d = 1'b1;
    end else if (state_q == S_OVER && !game_over) begin
      state_d = S_SCORE;
      dwell_d = '0;
    end else if (msg_req && (state_q == S_SCORE || state_q == S_LEVEL)) begin
      msg_d    = msg_val;
      state_d  = S_MSG;
      dwell_d  = '0;
      ack_d    = 1'b1;
      resume_d = (state_q == S_SCORE) ? S_SCORE : S_LEVEL;
    end else if (msg_req && state_q == S_MSG) begin
      msg_d   = msg_val;
      dwell_d = '0;
      ack_d   = 1'b1;
    end else if (tick) begin
      if (dwell_inc == lim) begin
        dwell_d = '0;
        case (state_q)
          S_SCORE: state_d = S_LEVEL;
          S_LEVEL: state_d = S_SCORE;
          S_MSG:   state_d = resume_q;
          S_OVER:  phase_d = ~phase_q;
          default: state_d = S_SCORE;
        endcase
      end else begin
        dwell_d = dwell_inc;
      end
    end

    disp_d = score_val;
    en_d   = 4'b1111;
    case (state_d)
      S_SCORE: begin
        disp_d = score_val;
        en_d   = (LZ_BLANK != 0) ? lz_mask(score_val) : 4'b1111;
      end
      S_LEVEL: begin
        disp_d = level_val;
        en_d   = (LZ_BLANK != 0) ? lz_mask(level_val) : 4'b1111;
      end
      S_MSG: begin
        disp_d = msg_d;
        en_d   = 4'b1111;
      end
      S_OVER: begin
        disp_d = score_val;
        en_d   = phase_d ? 4'b1111 : 4'b0000;
      end
      default: ;
    endcase
    src_d  = state_d;
    busy_d = (state_d == S_MSG);
  end

endmodule

// File: tb/tb_display_sched.sv
// Self-checking bench for display_sched: directed walk of the main scenarios,
// then randomized stimulus against a cycle-level behavioural model.
module tb_display_sched;

  localparam int PRESC = 4;
  localparam int ROT   = 3;
  localparam int MSGT  = 2;
  localparam int BLINK = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] score_val, level_val, msg_val;
  logic        msg_req, game_over;
  logic [15:0] disp_val;
  logic [3:0]  digit_en;
  logic [1:0]  src_sel;
  logic        msg_ack, msg_busy;

  int n_checks = 0;
  int n_errors = 0;

  // Model state: 0 score, 1 level, 2 message, 3 game over.
  int          m_state, m_resume, m_dwell, m_pc;
  bit          m_phase;
  logic [15:0] m_msg;
  logic [15:0] exp_disp;
  logic [3:0]  exp_en;
  logic [1:0]  exp_src;
  logic        exp_ack, exp_busy;

  display_sched #(
    .PRESC_DIV(PRESC), .ROT_TICKS(ROT), .MSG_TICKS(MSGT),
    .BLINK_TICKS(BLINK), .LZ_BLANK(1)
  ) dut (
    .clk(clk), .rst(rst), .score_val(score_val), .level_val(level_val),
    .msg_val(msg_val), .msg_req(msg_req), .game_over(game_over),
    .disp_val(disp_val), .digit_en(digit_en), .src_sel(src_sel),
    .msg_ack(msg_ack), .msg_busy(msg_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Digits 0..highest nonzero nibble are lit.
  function automatic logic [3:0] blank_mask(input logic [15:0] v);
    int k = 0;
    for (int i = 0; i < 4; i++)
      if (((v >> (4 * i)) & 16'hF) != 0) k = i;
    return 4'((1 << (k + 1)) - 1);
  endfunction

  function automatic int limit_of(input int st);
    if (st == 2) return MSGT;
    if (st == 3) return BLINK;
    return ROT;
  endfunction

  // Predict the registered outputs after the coming clock edge.
  task automatic model_step();
    bit tk;
    exp_ack = 1'b0;
    if (rst) begin
      m_state = 0; m_resume = 0; m_dwell = 0; m_pc = 0; m_phase = 1; m_msg = '0;
      exp_disp = '0; exp_en = 4'b0001; exp_src = 2'd0; exp_busy = 1'b0;
      return;
    end
    tk   = (m_pc == PRESC - 1);
    m_pc = tk ? 0 : m_pc + 1;
    if (game_over && m_state != 3) begin
      m_state = 3; m_dwell = 0; m_phase = 1;
    end else if (m_state == 3 && !game_over) begin
      m_state = 0; m_dwell = 0;
    end else if (msg_req && m_state < 2) begin
      m_resume = m_state; m_state = 2; m_msg = msg_val; m_dwell = 0; exp_ack = 1'b1;
    end else if (msg_req && m_state == 2) begin
      m_msg = msg_val; m_dwell = 0; exp_ack = 1'b1;
    end else if (tk) begin
      m_dwell++;
      if (m_dwell == limit_of(m_state)) begin
        m_dwell = 0;
        case (m_state)
          0: m_state = 1;
          1: m_state = 0;
          2: m_state = m_resume;
          default: m_phase = !m_phase;
        endcase
      end
    end
    exp_src  = 2'(m_state);
    exp_busy = (m_state == 2);
    case (m_state)
      0: begin exp_disp = score_val; exp_en = blank_mask(score_val); end
      1: begin exp_disp = level_val; exp_en = blank_mask(level_val); end
      2: begin exp_disp = m_msg;     exp_en = 4'b1111; end
      default: begin exp_disp = score_val; exp_en = m_phase ? 4'b1111 : 4'b0000; end
    endcase
  endtask

  // One clock: predict, advance, compare all outputs, clear the request pulse.
  task automatic cyc();
    model_step();
    @(posedge clk);
    @(negedge clk);
    check("disp_val", 32'(disp_val), 32'(exp_disp));
    check("digit_en", 32'(digit_en), 32'(exp_en));
    check("src_sel",  32'(src_sel),  32'(exp_src));
    check("msg_ack",  32'(msg_ack),  32'(exp_ack));
    check("msg_busy", 32'(msg_busy), 32'(exp_busy));
    msg_req = 1'b0;
  endtask

  initial begin
    bit found;
    rst = 1'b1; score_val = 16'h0042; level_val = 16'h0003;
    msg_val = '0; msg_req = 1'b0; game_over = 1'b0;
    cyc(); cyc();
    check("rst_disp", 32'(disp_val), 32'h0);
    check("rst_en",   32'(digit_en), 32'h1);
    check("rst_src",  32'(src_sel),  32'h0);

    // Rotation: score for 3 ticks, then level, then score.
    rst = 1'b0;
    cyc();
    check("score_disp", 32'(disp_val), 32'h0042);
    check("score_en",   32'(digit_en), 32'h3);
    repeat (10) cyc();
    check("pre_rot_src", 32'(src_sel), 32'd0);
    cyc();
    check("level_src",  32'(src_sel),  32'd1);
    check("level_disp", 32'(disp_val), 32'h0003);
    check("level_en",   32'(digit_en), 32'h1);
    repeat (12) cyc();
    check("back_score", 32'(src_sel), 32'd0);
    repeat (12) cyc();
    check("level2_src", 32'(src_sel), 32'd1);

    // Message from S_LEVEL, then a replacement one tick in.
    msg_val = 16'hDEAD; msg_req = 1'b1;
    cyc();
    check("msg_ack", 32'(msg_ack), 32'd1);
    check("msg_src", 32'(src_sel), 32'd2);
    check("msg_disp", 32'(disp_val), 32'hDEAD);
    repeat (3) cyc();
    msg_val = 16'hBEEF; msg_req = 1'b1;
    cyc();
    check("msg2_ack",  32'(msg_ack),  32'd1);
    check("msg2_disp", 32'(disp_val), 32'hBEEF);
    repeat (6) cyc();
    check("msg2_hold", 32'(src_sel), 32'd2);
    cyc();
    check("msg2_resume", 32'(src_sel), 32'd1);
    repeat (11) cyc();
    check("full_dwell", 32'(src_sel), 32'd1);
    cyc();
    check("after_dwell", 32'(src_sel), 32'd0);

    // Game over with a simultaneous request.
    game_over = 1'b1; msg_req = 1'b1; msg_val = 16'h1111;
    cyc();
    check("over_src", 32'(src_sel), 32'd3);
    check("over_ack", 32'(msg_ack), 32'd0);
    check("over_en",  32'(digit_en), 32'hF);
    repeat (15) cyc();
    game_over = 1'b0;
    cyc();
    check("over_exit", 32'(src_sel), 32'd0);

    // Request on the very tick that ends the score dwell.
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      if (m_state == 0 && m_pc == PRESC - 1 && m_dwell == ROT - 1) found = 1'b1;
      else cyc();
    end
    check("coinc_found", 32'(found), 32'd1);
    msg_val = 16'h1234; msg_req = 1'b1;
    cyc();
    check("coinc_src", 32'(src_sel), 32'd2);
    repeat (8) cyc();
    check("coinc_resume", 32'(src_sel), 32'd0);

    // Reset in the middle of a message discards it.
    msg_val = 16'h5555; msg_req = 1'b1;
    cyc();
    rst = 1'b1;
    cyc();
    check("rst_msg_disp", 32'(disp_val), 32'h0);
    check("rst_msg_en",   32'(digit_en), 32'h1);
    check("rst_msg_busy", 32'(msg_busy), 32'h0);
    rst = 1'b0;
    cyc();
    check("post_rst_src", 32'(src_sel), 32'd0);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 79) == 0) game_over = !game_over;
      msg_req = ($urandom_range(0, 24) == 0);
      msg_val = 16'($urandom);
      if ($urandom_range(0, 15) == 0) begin
        case ($urandom_range(0, 4))
          0: score_val = 16'h0000;
          1: score_val = 16'($urandom) & 16'h000F;
          2: score_val = 16'($urandom) & 16'h00FF;
          3: score_val = 16'($urandom) & 16'h0FFF;
          default: score_val = 16'($urandom);
        endcase
      end
      if ($urandom_range(0, 15) == 0)
        level_val = 16'($urandom) & (16'hFFFF >> (4 * $urandom_range(0, 3)));
      cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
